// File: rtl/fir_pkg.sv
// -----------------------------------------------------------------------------
// fir_pkg
// Shared constants for the FIR output requantization path.
//   DEF_ACC_W : default signed width of the FIR accumulator result
//   DEF_OUT_W : default signed output sample width (Q1.16)
//   DEF_SHIFT : default number of fractional accumulator bits discarded
//   OUT_MAX   : largest representable output sample at DEF_OUT_W
//   OUT_MIN   : smallest representable output sample at DEF_OUT_W
// -----------------------------------------------------------------------------
package fir_pkg;

  localparam int DEF_ACC_W = 41;
  localparam int DEF_OUT_W = 17;
  localparam int DEF_SHIFT = 16;

  localparam int OUT_MAX = (2 ** (DEF_OUT_W - 1)) - 1;
  localparam int OUT_MIN = -(2 ** (DEF_OUT_W - 1));

endpackage : fir_pkg

// File: rtl/fir_sync_fifo.sv
// -----------------------------------------------------------------------------
// fir_sync_fifo
// Single-clock first-word-fall-through FIFO for requantized samples.
//   clk       : rising-edge clock
//   reset     : synchronous active-high reset (pointers and level only)
//   push      : write push_data this cycle (accepted if not full, or if a pop
//               happens in the same cycle)
//   push_data : sample to store
//   pop       : remove the head sample (ignored while empty)
//   pop_data  : head sample, forced to zero while the FIFO is empty
//   level     : number of stored samples, 0..DEPTH
//   full      : level == DEPTH
//   empty     : level == 0
// DEPTH must be a power of two so that the pointers wrap naturally.
// -----------------------------------------------------------------------------
module fir_sync_fifo
  import fir_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int OUT_W = DEF_OUT_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [OUT_W-1:0]         push_data,
  input  logic                     pop,
  output logic [OUT_W-1:0]         pop_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [OUT_W-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             wr_en;
  logic             rd_en;

  assign empty = (level == '0);
  assign full  = (level == (AW+1)'(DEPTH));

  // A push into a full FIFO still lands when the head leaves in the same
  // cycle: the slot being vacated is the one the write pointer points at.
  assign rd_en = pop && !empty;
  assign wr_en = push && (!full || rd_en);

  // Zero while empty so stale storage never shows on the output.
  assign pop_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= push_data;
  end

endmodule : fir_sync_fifo

// File: rtl/fir_result_requantizer.sv
// -----------------------------------------------------------------------------
// fir_result_requantizer
// Rounds a wide signed FIR accumulator to Q1.16, saturates it and queues the
// result in a FWFT FIFO towards a ready/valid consumer.
//   clk        : rising-edge clock
//   reset      : synchronous active-high reset
//   acc_valid  : acc_in is valid this cycle (no backpressure upstream)
//   acc_in     : signed accumulator result, ACC_W bits
//   out_data   : signed requantized head sample, OUT_W bits (0 when empty)
//   out_valid  : FIFO holds at least one sample
//   out_ready  : downstream takes out_data this cycle
//   fifo_level : samples currently stored
//   sat_flag   : sticky, set whenever a sample was clamped
//   sat_clr    : clears sat_flag (a simultaneous set wins)
//   drop_count : samples lost to a full FIFO, saturates at 65535
// Latency: sample at cycle N is registered rounded at the end of N, saturated
// and written at the end of N+1, visible at N+2 when the FIFO was empty.
// -----------------------------------------------------------------------------
module fir_result_requantizer
  import fir_pkg::*;
#(
  parameter int ACC_W = DEF_ACC_W,
  parameter int OUT_W = DEF_OUT_W,
  parameter int SHIFT = DEF_SHIFT,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     acc_valid,
  input  logic signed [ACC_W-1:0]  acc_in,
  output logic signed [OUT_W-1:0]  out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     sat_flag,
  input  logic                     sat_clr,
  output logic [15:0]              drop_count
);

  // Width of the rounded value: the ACC_W+1 sum shifted right by SHIFT.
  localparam int RND_W = ACC_W + 1 - SHIFT;

  localparam logic signed [ACC_W:0] HALF_LSB =
    {{ACC_W{1'b0}}, 1'b1} << (SHIFT - 1);

  localparam logic signed [RND_W-1:0] SAT_HI =
    {{(RND_W - OUT_W + 1){1'b0}}, {(OUT_W - 1){1'b1}}};
  localparam logic signed [RND_W-1:0] SAT_LO =
    {{(RND_W - OUT_W + 1){1'b1}}, {(OUT_W - 1){1'b0}}};

  // Round half up: add half an output LSB one bit wider than the input so
  // the sum cannot wrap, then arithmetic-shift away the fractional bits.
  function automatic logic signed [RND_W-1:0] round_half_up(
    input logic signed [ACC_W-1:0] a
  );
    logic signed [ACC_W:0] wide;
    wide = {a[ACC_W-1], a};
    wide = wide + HALF_LSB;
    wide = wide >>> SHIFT;
    return RND_W'(wide);
  endfunction

  function automatic logic is_clamped(input logic signed [RND_W-1:0] v);
    return (v > SAT_HI) || (v < SAT_LO);
  endfunction

  function automatic logic signed [OUT_W-1:0] saturate(
    input logic signed [RND_W-1:0] v
  );
    logic signed [RND_W-1:0] c;
    if (v > SAT_HI)      c = SAT_HI;
    else if (v < SAT_LO) c = SAT_LO;
    else                 c = v;
    return OUT_W'(c);
  endfunction

  logic                     vld_p1;
  logic signed [RND_W-1:0]  rnd_p1;
  logic signed [OUT_W-1:0]  sat_p2;
  logic                     clamp_p2;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic                     fifo_pop;
  logic                     drop;
  logic [OUT_W-1:0]         fifo_head;

  // ---- stage 1: round, registered on valid cycles only ----
  always_ff @(posedge clk) begin
    if (reset) vld_p1 <= 1'b0;
    else       vld_p1 <= acc_valid;
  end

  always_ff @(posedge clk) begin
    if (acc_valid) rnd_p1 <= round_half_up(acc_in);
  end

  // ---- stage 2: saturate and write into the FIFO ----
  assign sat_p2   = saturate(rnd_p1);
  assign clamp_p2 = vld_p1 && is_clamped(rnd_p1);

  assign fifo_pop = out_ready && !fifo_empty;
  assign drop     = vld_p1 && fifo_full && !fifo_pop;

  fir_sync_fifo #(
    .DEPTH (DEPTH),
    .OUT_W (OUT_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (vld_p1),
    .push_data (sat_p2),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .level     (fifo_level),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign out_valid = !fifo_empty;
  assign out_data  = fifo_head;

  // Sticky saturation flag; a new clamp beats a simultaneous clear.
  always_ff @(posedge clk) begin
    if (reset)         sat_flag <= 1'b0;
    else if (clamp_p2) sat_flag <= 1'b1;
    else if (sat_clr)  sat_flag <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset)                              drop_count <= '0;
    else if (drop && (drop_count != 16'hFFFF)) drop_count <= drop_count + 16'd1;
  end

endmodule : fir_result_requantizer
